// File: rtl/mem_bus_ctrl.sv
// rtl/mem_bus_ctrl.sv - core-to-memory-bus req/gnt/rvalid handshake controller with core stall
// Optional build macro MEM_TIMEOUT_EN adds a REQ/WAIT cycle limit with a sticky bus_err flag.
module mem_bus_ctrl #(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = 255
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic          cpu_stall,
  output logic          cpu_rvalid,
  output logic [DW-1:0] cpu_rdata,
  output logic          bus_req,
  output logic          bus_we,
  output logic [AW-1:0] bus_addr,
  output logic [DW-1:0] bus_wdata,
  input  logic          bus_gnt,
  input  logic          bus_rvalid,
  input  logic [DW-1:0] bus_rdata,
  output logic          bus_err
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

  state_t state;
  logic   expire;
  logic   err_q;

  assign cpu_stall = ((state == IDLE) && cpu_req) || (state == REQ) || (state == WAIT);
  assign bus_err   = err_q;

`ifdef MEM_TIMEOUT_EN
  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  logic [CW-1:0] tmo_cnt;

  // Counts REQ+WAIT cycles of the current access; cleared as the access is accepted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tmo_cnt <= '0;
    end else if ((state == IDLE) && cpu_req) begin
      tmo_cnt <= '0;
    end else if ((state == REQ) || (state == WAIT)) begin
      tmo_cnt <= tmo_cnt + 1'b1;
    end
  end

  assign expire = ((state == REQ) || (state == WAIT)) && (tmo_cnt == CW'(TIMEOUT - 1));
`else
  // No expiry without the timeout build; the access waits for the bus indefinitely.
  assign expire = (TIMEOUT < 0);
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      bus_req    <= 1'b0;
      bus_we     <= 1'b0;
      bus_addr   <= '0;
      bus_wdata  <= '0;
      cpu_rvalid <= 1'b0;
      cpu_rdata  <= '0;
      err_q      <= 1'b0;
    end else begin
      cpu_rvalid <= 1'b0;
      case (state)
        IDLE: begin
          if (cpu_req) begin
            bus_addr  <= cpu_addr;
            bus_wdata <= cpu_wdata;
            bus_we    <= cpu_we;
            bus_req   <= 1'b1;
            state     <= REQ;
          end
        end
        REQ: begin
          // A grant in the expiry cycle wins over the timeout.
          if (bus_gnt) begin
            bus_req <= 1'b0;
            bus_we  <= 1'b0;
            if (bus_we) begin
              state <= DONE;
            end else if (bus_rvalid) begin
              cpu_rdata  <= bus_rdata;
              cpu_rvalid <= 1'b1;
              state      <= DONE;
            end else begin
              state <= WAIT;
            end
          end else if (expire) begin
            bus_req <= 1'b0;
            bus_we  <= 1'b0;
            err_q   <= 1'b1;
            if (!bus_we) begin
              cpu_rdata  <= DW'(32'hDEAD_BEEF);
              cpu_rvalid <= 1'b1;
            end
            state <= DONE;
          end
        end
        WAIT: begin
          if (bus_rvalid) begin
            cpu_rdata  <= bus_rdata;
            cpu_rvalid <= 1'b1;
            state      <= DONE;
          end else if (expire) begin
            err_q      <= 1'b1;
            cpu_rdata  <= DW'(32'hDEAD_BEEF);
            cpu_rvalid <= 1'b1;
            state      <= DONE;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_bus_ctrl.sv
// tb/tb_mem_bus_ctrl.sv - randomized transaction-level checking of mem_bus_ctrl against a timing model
// Timeout scenario runs only when MEM_TIMEOUT_EN is defined.
module tb_mem_bus_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cpu_req = 1'b0;
  logic        cpu_we = 1'b0;
  logic [31:0] cpu_addr = '0;
  logic [31:0] cpu_wdata = '0;
  logic        cpu_stall;
  logic        cpu_rvalid;
  logic [31:0] cpu_rdata;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic        bus_gnt = 1'b0;
  logic        bus_rvalid = 1'b0;
  logic [31:0] bus_rdata = '0;
  logic        bus_err;

  mem_bus_ctrl #(.AW(32), .DW(32), .TIMEOUT(8)) dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_stall(cpu_stall), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
    .bus_gnt(bus_gnt), .bus_rvalid(bus_rvalid), .bus_rdata(bus_rdata), .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Expected outputs for the current cycle, set by the driver from the access plan.
  logic        chk_en = 1'b0;
  logic        exp_stall, exp_req, exp_we, exp_rv, exp_err;
  logic [31:0] exp_addr, exp_wdata, exp_rdata;
  int          stall_seen = 0;
  int          rv_cnt = 0;
  int          rv_prev = 0;
  int          rv_last = 0;

  function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @cyc %0d: got %h expected %h", name, cyc, act, exp);
    end
  endfunction

  always @(negedge clk) begin
    if (chk_en) begin
      check("cpu_stall", cpu_stall, exp_stall);
      check("bus_req", bus_req, exp_req);
      check("bus_we", bus_we, exp_we);
      check("cpu_rvalid", cpu_rvalid, exp_rv);
      check("cpu_rdata", cpu_rdata, exp_rdata);
      check("bus_err", bus_err, exp_err);
      if (exp_req) check("bus_addr", bus_addr, exp_addr);
      if (exp_req && exp_we) check("bus_wdata", bus_wdata, exp_wdata);
      if (cpu_stall) stall_seen++;
      if (cpu_rvalid) begin
        rv_cnt++;
        rv_prev = rv_last;
        rv_last = cyc;
      end
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic set_exp(input logic s, input logic rq, input logic w, input logic rv);
    exp_stall = s;
    exp_req   = rq;
    exp_we    = w;
    exp_rv    = rv;
  endtask

  task automatic spurious();
    bus_rvalid = 1'($urandom_range(0, 1));
    bus_rdata  = 32'hFFFF_FFFF;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) begin
      next_cycle();
      cpu_req = 1'b0;
      bus_gnt = 1'b0;
      spurious();
      set_exp(1'b0, 1'b0, 1'b0, 1'b0);
    end
  endtask

  // One access: grant after g extra REQ cycles, read data r cycles after the grant.
  task automatic do_access(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                           input int g, input int r, input logic [31:0] rd);
    next_cycle();
    cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wdata;
    bus_gnt = 1'b0;
    spurious();
    set_exp(1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i <= g; i++) begin
      next_cycle();
      cpu_addr = $urandom; cpu_wdata = $urandom;
      bus_gnt = (i == g);
      if (i < g || we) spurious();
      else begin
        bus_rvalid = (r == 0);
        bus_rdata  = (r == 0) ? rd : $urandom;
      end
      set_exp(1'b1, 1'b1, we, 1'b0);
      exp_addr = addr; exp_wdata = wdata;
    end
    if (!we) begin
      for (int j = 1; j <= r; j++) begin
        next_cycle();
        bus_gnt = 1'b0;
        bus_rvalid = (j == r);
        bus_rdata  = (j == r) ? rd : $urandom;
        set_exp(1'b1, 1'b0, 1'b0, 1'b0);
      end
    end
    next_cycle();
    cpu_req = 1'($urandom_range(0, 1));
    bus_gnt = 1'b0;
    spurious();
    if (!we) exp_rdata = rd;
    set_exp(1'b0, 1'b0, 1'b0, !we);
  endtask

  initial begin
    int pulses_before;
    set_exp(1'b0, 1'b0, 1'b0, 1'b0);
    exp_err = 1'b0; exp_rdata = '0; exp_addr = '0; exp_wdata = '0;
    repeat (2) next_cycle();
    check("rst_bus_req", bus_req, 1'b0);
    check("rst_bus_we", bus_we, 1'b0);
    check("rst_cpu_rvalid", cpu_rvalid, 1'b0);
    check("rst_bus_err", bus_err, 1'b0);
    check("rst_bus_addr", bus_addr, 32'h0);
    check("rst_bus_wdata", bus_wdata, 32'h0);
    check("rst_cpu_rdata", cpu_rdata, 32'h0);
    check("rst_cpu_stall", cpu_stall, 1'b0);
    rst = 1'b0;
    chk_en = 1'b1;
    idle(3);

    // Store with spurious read data around it.
    do_access(1'b1, 32'h100, 32'hA5A5_A5A5, 0, 0, 32'h0);
    check("pin_store_no_rvalid", rv_cnt, 0);
    idle(2);

    // Load: grant 2 cycles late, data 3 cycles after grant.
    stall_seen = 0;
    do_access(1'b0, 32'h40, 32'h0, 2, 3, 32'h1234_5678);
    idle(1);
    check("pin_load_stall_cycles", stall_seen, 7);
    check("pin_load_rdata", cpu_rdata, 32'h1234_5678);
    check("pin_load_rvalid_cnt", rv_cnt, 1);

    // Two back-to-back zero-wait fetches, 3 cycles apart.
    pulses_before = rv_cnt;
    do_access(1'b0, 32'h0, 32'h0, 0, 0, 32'h0050_0093);
    do_access(1'b0, 32'h4, 32'h0, 0, 0, 32'h0050_0093);
    idle(1);
    check("pin_fetch_pulses", rv_cnt - pulses_before, 2);
    check("pin_fetch_spacing", rv_last - rv_prev, 3);
    check("pin_fetch_rdata", cpu_rdata, 32'h0050_0093);

    for (int t = 0; t < 150; t++) begin
      do_access(1'($urandom_range(0, 1)), $urandom, $urandom,
                $urandom_range(0, 3), $urandom_range(0, 3), $urandom);
      if ($urandom_range(0, 1) == 1) idle($urandom_range(1, 2));
    end
    idle(1);

`ifdef MEM_TIMEOUT_EN
    next_cycle();
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h80; bus_gnt = 1'b0;
    spurious();
    set_exp(1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) begin
      next_cycle();
      bus_gnt = 1'b0;
      spurious();
      set_exp(1'b1, 1'b1, 1'b0, 1'b0);
      exp_addr = 32'h80;
    end
    next_cycle();
    cpu_req = 1'b0;
    spurious();
    exp_err = 1'b1; exp_rdata = 32'hDEAD_BEEF;
    set_exp(1'b0, 1'b0, 1'b0, 1'b1);
    idle(1);
    check("pin_tmo_rdata", cpu_rdata, 32'hDEAD_BEEF);
    check("pin_tmo_err", bus_err, 1'b1);
    do_access(1'b1, 32'h200, 32'h1, 0, 0, 32'h0);
    do_access(1'b0, 32'h204, 32'h0, 1, 2, 32'hCAFE_0001);
    idle(1);
    check("pin_tmo_err_sticky", bus_err, 1'b1);
`endif

    // Asynchronous reset while a read sits in WAIT.
    next_cycle();
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h300; bus_gnt = 1'b0; bus_rvalid = 1'b0;
    set_exp(1'b1, 1'b0, 1'b0, 1'b0);
    next_cycle();
    bus_gnt = 1'b1; bus_rvalid = 1'b0;
    set_exp(1'b1, 1'b1, 1'b0, 1'b0);
    exp_addr = 32'h300;
    next_cycle();
    bus_gnt = 1'b0;
    set_exp(1'b1, 1'b0, 1'b0, 1'b0);
    #2;
    chk_en = 1'b0;
    rst = 1'b1;
    cpu_req = 1'b0;
    #1;
    check("midrst_bus_req", bus_req, 1'b0);
    check("midrst_cpu_stall", cpu_stall, 1'b0);
    check("midrst_cpu_rdata", cpu_rdata, 32'h0);
    check("midrst_bus_err", bus_err, 1'b0);
    next_cycle();
    rst = 1'b0;
    exp_err = 1'b0; exp_rdata = '0;
    set_exp(1'b0, 1'b0, 1'b0, 1'b0);
    chk_en = 1'b1;
    idle(2);
    do_access(1'b0, 32'h44, 32'h0, 1, 1, 32'h7777_0000);
    do_access(1'b1, 32'h48, 32'h9, 2, 0, 32'h0);
    idle(2);
    chk_en = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/mem_bus_ctrl.md
Name: mem_bus_ctrl

Overview:
Memory-side handshake controller between the multicycle core datapath (address mux, MemWrite, IRWrite) and a variable-latency memory bus. It captures one fetch, load or store request, runs a req/gnt and rvalid handshake on the bus, and holds the core with cpu_stall until the access completes. The core's state register advances only when cpu_stall=0. Read data returns through cpu_rdata/cpu_rvalid to the instruction and data registers.

Parameters:
AW, 32, address width
DW, 32, data width
TIMEOUT, 255, max cycles in REQ+WAIT before abort (only with MEM_TIMEOUT_EN)

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
cpu_req  in  1  access request, level; held high by core while stalled
cpu_we  in  1  1=store, 0=fetch/load
cpu_addr  in  AW  byte address
cpu_wdata  in  DW  store data
cpu_stall  out  1  core hold
cpu_rvalid  out  1  one-cycle pulse, read data valid
cpu_rdata  out  DW  last read data, held
bus_req  out  1  bus request
bus_we  out  1  bus write strobe
bus_addr  out  AW  registered address
bus_wdata  out  DW  registered write data
bus_gnt  in  1  bus accepts request
bus_rvalid  in  1  read data valid
bus_rdata  in  DW  read data
bus_err  out  1  sticky timeout flag

Behaviour:
- Reset: state IDLE; bus_req, bus_we, cpu_rvalid, bus_err = 0; bus_addr, bus_wdata, cpu_rdata = 0. Async assert mid-access aborts immediately; no bus signal stays asserted.
- States: IDLE, REQ, WAIT, DONE (2-bit encoding).
- IDLE:
  - cpu_req=1 -> latch cpu_addr/cpu_we/cpu_wdata into bus_addr/bus_we/bus_wdata; go REQ.
  - cpu_req=0 -> stay IDLE.
- REQ:
  - bus_req=1; bus_addr/bus_we/bus_wdata stable until gnt.
  - bus_gnt=1 and write -> DONE.
  - bus_gnt=1 and read, bus_rvalid=0 -> WAIT.
  - bus_gnt=1 and read, bus_rvalid=1 -> capture bus_rdata; go DONE (zero-wait read).
  - bus_gnt=0 -> stay REQ.
- WAIT:
  - bus_req=0, bus_we=0.
  - bus_rvalid=1 -> capture bus_rdata into cpu_rdata; go DONE.
- DONE:
  - cpu_rvalid=1 for reads only; go IDLE unconditionally.
  - cpu_req ignored this cycle; the core presents its next request from IDLE onward.
- cpu_stall (combinational) = (IDLE & cpu_req) | REQ | WAIT. It is 0 in DONE, which releases the core.
- bus_we is asserted only together with bus_req, and is 0 outside REQ.
- bus_rvalid is ignored in IDLE, in DONE, in REQ without gnt, and for writes.
- cpu_rdata changes only on read capture; it holds its value across writes and idle cycles.
- Latency: write, gnt in first REQ cycle -> 3 cycles req-to-release (IDLE, REQ, DONE).
- Latency: zero-wait read -> 3 cycles; read with rvalid N cycles after gnt -> 3+N.
- Back-to-back requests: minimum 3 cycles per access; no pipelining and no outstanding-request queue.

Optional Feature:
MEM_TIMEOUT_EN
- Defined:
  - A counter clears on entry to REQ and increments each cycle in REQ/WAIT.
  - When it reaches TIMEOUT: set bus_err (sticky until rst), drop bus_req, go DONE.
  - For reads, cpu_rdata is forced to 32'hDEADBEEF with cpu_rvalid=1.
  - A gnt/rvalid arriving in the same cycle as expiry takes priority over the timeout.
- Undefined: no counter; the controller waits indefinitely; bus_err tied 0.

Test Plan:
- Reset mid-WAIT (rst pulsed during read) -> next cycle: state IDLE, bus_req=0, cpu_stall=0, cpu_rdata=0.
- Store addr=0x100, wdata=0xA5A5A5A5, gnt on first REQ cycle -> bus_req=1, bus_we=1 for exactly 1 cycle; stall released 3rd cycle; cpu_rvalid never 1.
- Load addr=0x40, gnt delayed 2 cycles, rvalid 3 cycles after gnt with rdata=0x12345678 -> cpu_rvalid pulse on DONE; cpu_rdata=0x12345678 held; stall high every cycle until DONE.
- Zero-wait fetch: gnt=rvalid=1 in first REQ cycle, rdata=0x00500093 -> cpu_rvalid in cycle 3; two back-to-back fetches complete in 6 cycles.
- Spurious bus_rvalid=1 with rdata=0xFFFFFFFF while IDLE and during a store -> cpu_rdata unchanged; no cpu_rvalid.
- With MEM_TIMEOUT_EN, TIMEOUT=8, load, bus_gnt never asserted -> bus_err=1 after 8 REQ cycles; cpu_rdata=0xDEADBEEF with cpu_rvalid=1; bus_err stays 1 through later accesses until rst.
